// File: rtl/wait_state_ram_pkg.sv
// Purpose : shared types and constants for the wait-state RAM.
// Contents: FSM state encoding, lane/counter/data widths, and the AW helper.
package wait_state_ram_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RWAIT = 2'd1,
        ST_WWAIT = 2'd2
    } state_t;

    // Word-index width for a power-of-two depth.
    function automatic int unsigned calc_aw(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/wait_state_ram_if.sv
// Purpose : processor-side memory bus of the wait-state RAM.
// Signals : mem_addr/mem_rstrb/mem_wdata/mem_wmask (requester -> memory),
//           mem_rdata/mem_rbusy/mem_wbusy/mem_err (memory -> requester).
interface wait_state_ram_if;
    import wait_state_ram_pkg::*;

    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_rstrb;
    logic [DATA_W-1:0]    mem_wdata;
    logic [NUM_LANES-1:0] mem_wmask;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 mem_rbusy;
    logic                 mem_wbusy;
    logic                 mem_err;

    modport master (
        output mem_addr, mem_rstrb, mem_wdata, mem_wmask,
        input  mem_rdata, mem_rbusy, mem_wbusy, mem_err
    );

    modport slave (
        input  mem_addr, mem_rstrb, mem_wdata, mem_wmask,
        output mem_rdata, mem_rbusy, mem_wbusy, mem_err
    );

endinterface

// File: rtl/wait_state_ram_ram_core.sv
// Purpose : single-port DEPTH_WORDS x 32 array, byte-enabled synchronous
//           write, combinational read gated by read enable.
// Ports   : clk, i_addr (word index), i_re, i_be (per-byte write enable),
//           i_wdata, o_rdata_c (combinational read data).
module wait_state_ram_ram_core
    import wait_state_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic                 clk,
    input  logic [AW-1:0]        i_addr,
    input  logic                 i_re,
    input  logic [NUM_LANES-1:0] i_be,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic [DATA_W-1:0]    o_rdata_c
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // Byte-lane write: lane k covers bits [8k+7:8k].
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            if (i_be[k]) begin
                r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
    end

    assign o_rdata_c = i_re ? r_mem[i_addr] : '0;

endmodule

// File: rtl/wait_state_ram.sv
// Purpose : RAM with programmable read/write wait states, busy handshakes
//           and a sticky error flag for protocol and range violations.
// Ports   : clk, reset_n (async active-low), bus (slave modport carrying
//           mem_addr/rstrb/wdata/wmask in and mem_rdata/rbusy/wbusy/err out).
module wait_state_ram
    import wait_state_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned READ_WAIT   = 0,
    parameter int unsigned WRITE_WAIT  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    wait_state_ram_if.slave  bus
);

    localparam int unsigned AW = calc_aw(DEPTH_WORDS);

    state_t               r_state, w_state_n;
    logic [CNT_W-1:0]     r_cnt, w_cnt_n;
    logic [AW-1:0]        r_idx, w_idx_n;
    logic [DATA_W-1:0]    r_wdata, w_wdata_n;
    logic [NUM_LANES-1:0] r_wmask, w_wmask_n;
    logic                 r_oor, w_oor_n;
    logic [DATA_W-1:0]    r_rdata, w_rdata_n;
    logic                 r_rbusy, w_rbusy_n;
    logic                 r_wbusy, w_wbusy_n;
    logic                 r_err, w_err_n;

    logic [AW-1:0]        w_idx;
    logic                 w_oor;
    logic                 w_rd_req;
    logic                 w_wr_req;
    logic [AW-1:0]        w_ram_addr;
    logic                 w_ram_re;
    logic [NUM_LANES-1:0] w_ram_be;
    logic [DATA_W-1:0]    w_ram_wdata;
    logic [DATA_W-1:0]    w_ram_rdata_c;

    assign w_idx    = bus.mem_addr[AW+1:2];
    assign w_oor    = (bus.mem_addr >> (AW + 2)) != '0;
    assign w_rd_req = bus.mem_rstrb;
    assign w_wr_req = |bus.mem_wmask;

    // Next-state, datapath and array-port control.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_idx_n     = r_idx;
        w_wdata_n   = r_wdata;
        w_wmask_n   = r_wmask;
        w_oor_n     = r_oor;
        w_rdata_n   = r_rdata;
        w_rbusy_n   = r_rbusy;
        w_wbusy_n   = r_wbusy;
        w_err_n     = r_err;
        w_ram_addr  = r_idx;
        w_ram_re    = 1'b0;
        w_ram_be    = '0;
        w_ram_wdata = r_wdata;

        case (r_state)
            ST_IDLE: begin
                // Zero-wait operations use the live bus rather than the latches.
                w_ram_addr  = w_idx;
                w_ram_wdata = bus.mem_wdata;
                if (w_wr_req) begin
                    // Write wins a collision with a read strobe.
                    if (w_rd_req || w_oor) w_err_n = 1'b1;
                    w_idx_n   = w_idx;
                    w_wdata_n = bus.mem_wdata;
                    w_wmask_n = bus.mem_wmask;
                    w_oor_n   = w_oor;
                    if (WRITE_WAIT == 0) begin
                        w_ram_be = w_oor ? '0 : bus.mem_wmask;
                    end else begin
                        w_cnt_n   = CNT_W'(WRITE_WAIT - 1);
                        w_wbusy_n = 1'b1;
                        w_state_n = ST_WWAIT;
                    end
                end else if (w_rd_req) begin
                    if (w_oor) w_err_n = 1'b1;
                    w_idx_n = w_idx;
                    w_oor_n = w_oor;
                    if (READ_WAIT == 0) begin
                        w_ram_re  = 1'b1;
                        w_rdata_n = w_oor ? '0 : w_ram_rdata_c;
                    end else begin
                        w_cnt_n   = CNT_W'(READ_WAIT - 1);
                        w_rbusy_n = 1'b1;
                        w_state_n = ST_RWAIT;
                    end
                end
            end
            ST_RWAIT: begin
                if (w_rd_req || w_wr_req) w_err_n = 1'b1;
                if (r_cnt == '0) begin
                    w_ram_re  = 1'b1;
                    w_rdata_n = r_oor ? '0 : w_ram_rdata_c;
                    w_rbusy_n = 1'b0;
                    w_state_n = ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            ST_WWAIT: begin
                if (w_rd_req || w_wr_req) w_err_n = 1'b1;
                if (r_cnt == '0) begin
                    w_ram_be  = r_oor ? '0 : r_wmask;
                    w_wbusy_n = 1'b0;
                    w_state_n = ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_rbusy_n = 1'b0;
                w_wbusy_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_oor   <= 1'b0;
            r_rdata <= '0;
            r_rbusy <= 1'b0;
            r_wbusy <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_wdata <= w_wdata_n;
            r_wmask <= w_wmask_n;
            r_oor   <= w_oor_n;
            r_rdata <= w_rdata_n;
            r_rbusy <= w_rbusy_n;
            r_wbusy <= w_wbusy_n;
            r_err   <= w_err_n;
        end
    end

    wait_state_ram_ram_core #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram_core (
        .clk       (clk),
        .i_addr    (w_ram_addr),
        .i_re      (w_ram_re),
        .i_be      (w_ram_be),
        .i_wdata   (w_ram_wdata),
        .o_rdata_c (w_ram_rdata_c)
    );

    assign bus.mem_rdata = r_rdata;
    assign bus.mem_rbusy = r_rbusy;
    assign bus.mem_wbusy = r_wbusy;
    assign bus.mem_err   = r_err;

endmodule

// File: tb/tb_wait_state_ram.sv
// Purpose : self-checking bench for wait_state_ram using three instances:
//           dut0 (RW=0, WW=0), dut1 (RW=3, WW=2), dut2 (RW=1, WW=4).
module tb_wait_state_ram;
    import wait_state_ram_pkg::*;

    localparam int NDUT    = 3;
    localparam int TIMEOUT = 40;

    logic        clk;
    logic        rst_n     [NDUT];
    logic [31:0] tb_addr   [NDUT];
    logic [31:0] tb_wdata  [NDUT];
    logic        tb_rstrb  [NDUT];
    logic [3:0]  tb_wmask  [NDUT];
    logic [31:0] obs_rdata [NDUT];
    logic        obs_rbusy [NDUT];
    logic        obs_wbusy [NDUT];
    logic        obs_err   [NDUT];

    logic [31:0] model_mem [NDUT][256];
    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    wait_state_ram_if bus[NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_bus
        assign bus[g].mem_addr  = tb_addr[g];
        assign bus[g].mem_rstrb = tb_rstrb[g];
        assign bus[g].mem_wdata = tb_wdata[g];
        assign bus[g].mem_wmask = tb_wmask[g];
        assign obs_rdata[g]     = bus[g].mem_rdata;
        assign obs_rbusy[g]     = bus[g].mem_rbusy;
        assign obs_wbusy[g]     = bus[g].mem_wbusy;
        assign obs_err[g]       = bus[g].mem_err;
    end

    wait_state_ram #(.DEPTH_WORDS(256), .READ_WAIT(0), .WRITE_WAIT(0))
        u_dut0 (.clk(clk), .reset_n(rst_n[0]), .bus(bus[0]));
    wait_state_ram #(.DEPTH_WORDS(256), .READ_WAIT(3), .WRITE_WAIT(2))
        u_dut1 (.clk(clk), .reset_n(rst_n[1]), .bus(bus[1]));
    wait_state_ram #(.DEPTH_WORDS(256), .READ_WAIT(1), .WRITE_WAIT(4))
        u_dut2 (.clk(clk), .reset_n(rst_n[2]), .bus(bus[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:10] == 22'd0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_d, input logic [31:0] nd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_d;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = nd[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int k, input logic [31:0] addr);
        logic [7:0] idx;
        idx = addr[9:2];
        return in_range(addr) ? model_mem[k][idx] : 32'h0;
    endfunction

    // Issue one write and wait (bounded) for wbusy to drop; updates the model.
    task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input logic rd_too, output int busy);
        logic [7:0] idx;
        @(negedge clk);
        tb_addr[k] = addr; tb_wdata[k] = data; tb_wmask[k] = mask; tb_rstrb[k] = rd_too;
        @(posedge clk);
        @(negedge clk);
        tb_wmask[k] = 4'h0; tb_rstrb[k] = 1'b0;
        busy = 0;
        while (obs_wbusy[k] && busy < TIMEOUT) begin
            busy++;
            @(negedge clk);
        end
        idx = addr[9:2];
        if (in_range(addr)) model_mem[k][idx] = merge(model_mem[k][idx], data, mask);
    endtask

    // Issue one read; returns rdata just after acceptance and the busy length.
    task automatic do_read(input int k, input logic [31:0] addr, output int busy,
                           output logic [31:0] early);
        @(negedge clk);
        tb_addr[k] = addr; tb_rstrb[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_rstrb[k] = 1'b0;
        early = obs_rdata[k];
        busy = 0;
        while (obs_rbusy[k] && busy < TIMEOUT) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NDUT; k++) begin
            n_tests++;
            if ({obs_rdata[k], obs_rbusy[k], obs_wbusy[k], obs_err[k]} !== 35'h0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: rdata=%h rbusy=%b wbusy=%b err=%b required all 0",
                         k, obs_rdata[k], obs_rbusy[k], obs_wbusy[k], obs_err[k]);
            end
        end
    endtask

    task automatic test_read_zero_wait();
        int busy;
        logic [31:0] early, exp;
        do_write(0, 32'h0C, 32'hDEADBEEF, 4'hF, 1'b0, busy);
        n_tests++;
        if (busy !== 0) begin
            n_fail++; $display("FAIL rw0_write_busy: got %0d required 0", busy);
        end
        exp_q.push_back(32'hDEADBEEF);
        do_read(0, 32'h0C, busy, early);
        exp = exp_q.pop_front();
        n_tests++;
        if (busy !== 0) begin
            n_fail++; $display("FAIL rw0_read_busy: got %0d required 0", busy);
        end
        n_tests++;
        if (early !== exp) begin
            n_fail++; $display("FAIL rw0_rdata: got %h required %h", early, exp);
        end
        n_tests++;
        if (obs_err[0] !== 1'b0) begin
            n_fail++; $display("FAIL rw0_err: got %b required 0", obs_err[0]);
        end
    endtask

    task automatic test_collision();
        int busy;
        logic [31:0] early, exp;
        do_write(0, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1, busy);
        n_tests++;
        if (obs_rdata[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL collide_rdata_held: got %h required DEADBEEF", obs_rdata[0]);
        end
        n_tests++;
        if (obs_err[0] !== 1'b1) begin
            n_fail++; $display("FAIL collide_err: got %b required 1", obs_err[0]);
        end
        exp_q.push_back(model_read(0, 32'h20));
        do_read(0, 32'h20, busy, early);
        exp = exp_q.pop_front();
        n_tests++;
        if (early !== exp || exp !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL collide_write_committed: got %h required CAFEF00D", early);
        end
    endtask

    task automatic test_read_wait();
        int busy;
        logic [31:0] early, exp;
        do_write(1, 32'h0C, 32'hDEADBEEF, 4'hF, 1'b0, busy);
        n_tests++;
        if (busy !== 2) begin
            n_fail++; $display("FAIL rw3_write_busy: got %0d required 2", busy);
        end
        exp_q.push_back(model_read(1, 32'h0C));
        do_read(1, 32'h0C, busy, early);
        n_tests++;
        if (early !== 32'h0) begin
            n_fail++; $display("FAIL rw3_rdata_early: got %h required 00000000", early);
        end
        n_tests++;
        if (busy !== 3) begin
            n_fail++; $display("FAIL rw3_read_busy: got %0d required 3", busy);
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (obs_rdata[1] !== exp) begin
            n_fail++; $display("FAIL rw3_rdata: got %h required %h", obs_rdata[1], exp);
        end
        n_tests++;
        if (obs_err[1] !== 1'b0) begin
            n_fail++; $display("FAIL rw3_err: got %b required 0", obs_err[1]);
        end
    endtask

    task automatic test_byte_mask();
        int busy_a, busy_b, busy;
        logic [31:0] early, exp;
        do_write(1, 32'h14, 32'h11223344, 4'hF, 1'b0, busy_a);
        do_write(1, 32'h14, 32'hAABBCCDD, 4'b0101, 1'b0, busy_b);
        n_tests++;
        if (busy_a !== 2 || busy_b !== 2) begin
            n_fail++; $display("FAIL mask_write_busy: got %0d/%0d required 2/2", busy_a, busy_b);
        end
        exp_q.push_back(32'h11BB33DD);
        do_read(1, 32'h14, busy, early);
        exp = exp_q.pop_front();
        n_tests++;
        if (obs_rdata[1] !== exp) begin
            n_fail++; $display("FAIL mask_rdata: got %h required %h", obs_rdata[1], exp);
        end
    endtask

    task automatic test_back_to_back();
        int busy;
        logic [31:0] early, exp;
        logic [31:0] addr;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h20 + 32'(4 * i);
            do_write(1, addr, 32'hFFFF_FFFF, 4'hF, 1'b0, busy);
            do_write(1, addr, $urandom, 4'($urandom_range(1, 15)), 1'b0, busy);
            n_tests++;
            if (busy !== 2) begin
                n_fail++; $display("FAIL b2b_write_busy[%0d]: got %0d required 2", i, busy);
            end
        end
        for (int i = 0; i < 4; i++) begin
            addr = 32'h20 + 32'(4 * i);
            exp_q.push_back(model_read(1, addr));
            do_read(1, addr, busy, early);
            exp = exp_q.pop_front();
            n_tests++;
            if (busy !== 3) begin
                n_fail++; $display("FAIL b2b_read_busy[%0d]: got %0d required 3", i, busy);
            end
            n_tests++;
            if (obs_rdata[1] !== exp) begin
                n_fail++; $display("FAIL b2b_rdata[%0d]: got %h required %h", i, obs_rdata[1], exp);
            end
        end
    endtask

    task automatic test_protocol();
        int busy;
        logic [31:0] exp;
        exp_q.push_back(32'h11BB33DD);
        @(negedge clk);
        tb_addr[1] = 32'h14; tb_rstrb[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_addr[1] = 32'h0C;
        @(posedge clk);
        @(negedge clk);
        tb_rstrb[1] = 1'b0;
        n_tests++;
        if (obs_err[1] !== 1'b1) begin
            n_fail++; $display("FAIL rwait_violation_err: got %b required 1", obs_err[1]);
        end
        busy = 0;
        while (obs_rbusy[1] && busy < TIMEOUT) begin
            busy++;
            @(negedge clk);
        end
        n_tests++;
        if (busy !== 2) begin
            n_fail++; $display("FAIL rwait_violation_busy_tail: got %0d required 2", busy);
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (obs_rdata[1] !== exp) begin
            n_fail++; $display("FAIL rwait_violation_rdata: got %h required %h", obs_rdata[1], exp);
        end
    endtask

    task automatic test_out_of_range();
        int busy;
        logic [31:0] early, exp;
        @(negedge clk); rst_n[0] = 1'b0;
        @(negedge clk); rst_n[0] = 1'b1;
        exp_q.push_back(model_read(0, 32'h0C));
        do_read(0, 32'h0C, busy, early);
        exp = exp_q.pop_front();
        n_tests++;
        if (early !== exp) begin
            n_fail++; $display("FAIL oor_preread: got %h required %h", early, exp);
        end
        n_tests++;
        if (obs_err[0] !== 1'b0) begin
            n_fail++; $display("FAIL oor_err_before: got %b required 0", obs_err[0]);
        end
        exp_q.push_back(model_read(0, 32'h400));
        do_read(0, 32'h400, busy, early);
        exp = exp_q.pop_front();
        n_tests++;
        if (early !== exp || exp !== 32'h0) begin
            n_fail++; $display("FAIL oor_read_rdata: got %h required 00000000", early);
        end
        n_tests++;
        if (obs_err[0] !== 1'b1) begin
            n_fail++; $display("FAIL oor_read_err: got %b required 1", obs_err[0]);
        end
        do_write(0, 32'h0, 32'h01020304, 4'hF, 1'b0, busy);
        do_write(0, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b0, busy);
        exp_q.push_back(model_read(0, 32'h0));
        do_read(0, 32'h0, busy, early);
        exp = exp_q.pop_front();
        n_tests++;
        if (early !== exp || exp !== 32'h01020304) begin
            n_fail++; $display("FAIL oor_write_no_alias: got %h required 01020304", early);
        end
        do_write(1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b0, busy);
        n_tests++;
        if (busy !== 2) begin
            n_fail++; $display("FAIL oor_write_wait: got %0d required 2", busy);
        end
    endtask

    task automatic test_reset_mid_write();
        int busy;
        logic [31:0] early, exp;
        do_write(2, 32'h1C, 32'h55AA55AA, 4'hF, 1'b0, busy);
        n_tests++;
        if (busy !== 4) begin
            n_fail++; $display("FAIL ww4_write_busy: got %0d required 4", busy);
        end
        @(negedge clk);
        tb_addr[2] = 32'h1C; tb_wdata[2] = 32'h0; tb_wmask[2] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        tb_wmask[2] = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n[2] = 1'b0;
        #1;
        n_tests++;
        if (obs_wbusy[2] !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_wbusy: got %b required 0", obs_wbusy[2]);
        end
        repeat (5) @(negedge clk);
        rst_n[2] = 1'b1;
        exp_q.push_back(model_read(2, 32'h1C));
        do_read(2, 32'h1C, busy, early);
        exp = exp_q.pop_front();
        n_tests++;
        if (busy !== 1) begin
            n_fail++; $display("FAIL post_reset_read_busy: got %0d required 1", busy);
        end
        n_tests++;
        if (obs_rdata[2] !== exp || exp !== 32'h55AA55AA) begin
            n_fail++; $display("FAIL abandoned_write_rdata: got %h required 55AA55AA", obs_rdata[2]);
        end
        n_tests++;
        if (obs_err[2] !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_err: got %b required 0", obs_err[2]);
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            rst_n[k] = 1'b0;
            tb_addr[k] = '0; tb_wdata[k] = '0; tb_rstrb[k] = 1'b0; tb_wmask[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b1;
        @(negedge clk);

        test_reset();
        test_read_zero_wait();
        test_collision();
        test_read_wait();
        test_byte_mask();
        test_back_to_back();
        test_protocol();
        test_out_of_range();
        test_reset_mid_write();

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
